// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: parameterised bank of Y86-64 pipeline registers.
// Each stage has its own stall/bubble control. The whole bank freezes once the
// last stage holds a non-AOK status. Optional performance counters are built
// only when PIPE_PERF_EN is defined; otherwise the counter outputs read 0.

// One pipeline register: hold on stall, NOP on bubble, else load d.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // stat=AOK(1) in [2:0], icode=NOP(1) in [6:3], all other bits clear
  localparam logic [W-1:0] NOP = W'(9);

  // stage register; en low (halted) overrides every request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= NOP;
    else if (en && !stall) begin
      if (bubble)               q <= NOP;
      else                      q <= d;
    end
  end
endmodule

module pipe_stage_bank #(
  parameter int STAGES    = 4,
  parameter int PAYLOAD_W = 256,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [STAGES*PAYLOAD_W-1:0]   d_in,
  input  logic [STAGES-1:0]             stall,
  input  logic [STAGES-1:0]             bubble,
  output logic [STAGES*PAYLOAD_W-1:0]   q_out,
  output logic [2:0]                    stat,
  output logic                          halted,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W-1:0]              retire_cnt,
  output logic [CNT_W-1:0]              bubble_cnt
);
  localparam int LAST = STAGES - 1;
  // bubbles are counted at E; a single-stage bank counts at its only stage
  localparam int BI   = (STAGES > 1) ? 1 : 0;

  if (STAGES < 1 || PAYLOAD_W < 7) begin : g_bad_param
    $error("pipe_stage_bank: need STAGES>=1 and PAYLOAD_W>=7");
  end

  logic [STAGES-1:0][PAYLOAD_W-1:0] d_arr, q_arr;
  logic                             halt_q;
  logic                             halt_now;

  assign d_arr    = d_in;
  assign q_out    = q_arr;
  assign stat     = q_arr[LAST][2:0];
  assign halt_now = (q_arr[LAST][2:0] != 3'd1);
  assign halted   = halt_now | halt_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pipe_stage_reg #(.W(PAYLOAD_W)) u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (!halted),
      .stall  (stall[s]),
      .bubble (bubble[s]),
      .d      (d_arr[s]),
      .q      (q_arr[s])
    );
  end

  // sticky halt: once a non-AOK status reaches the last stage, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        halt_q <= 1'b0;
    else if (halt_now) halt_q <= 1'b1;
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q, bub_q;
  logic             retire_ev, bubble_ev;

  // a retire is a real (non-NOP) AOK instruction landing in the last stage;
  // the halting instruction has non-AOK stat and so never counts
  assign retire_ev = !stall[LAST] && !bubble[LAST] &&
                     (d_arr[LAST][2:0] == 3'd1) && (d_arr[LAST][6:3] != 4'd1);
  assign bubble_ev = bubble[BI] && !stall[BI];

  // saturating counters, frozen while halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
      bub_q <= '0;
    end else if (!halted) begin
      if (cyc_q != '1)              cyc_q <= cyc_q + 1'b1;
      if (retire_ev && ret_q != '1) ret_q <= ret_q + 1'b1;
      if (bubble_ev && bub_q != '1) bub_q <= bub_q + 1'b1;
    end
  end

  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
  assign bubble_cnt = bub_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised bank of pipeline registers for the Y86-64 pipeline (D, E, M, W and any added stages). Each register has per-stage stall/bubble control.
- Status-driven halt: once the last stage holds a non-AOK status, the whole pipeline freezes.
- Optional performance counters.
- Replaces the hand-written per-stage register blocks in the processor top, so deeper or wider pipelines reuse one block.

Parameters:
- STAGES, 4, number of pipeline registers; index 0 = first after fetch (D), STAGES-1 = last (W).
- PAYLOAD_W, 256, bits per stage payload. Bits [2:0] = stat, [6:3] = icode, remainder = stage fields. Minimum 7.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- d_in  input  STAGES*PAYLOAD_W  next-state payload per stage; slice s = [s*PAYLOAD_W +: PAYLOAD_W].
- stall  input  STAGES  per-stage hold request.
- bubble  input  STAGES  per-stage NOP-insert request.
- q_out  output  STAGES*PAYLOAD_W  registered payload per stage.
- stat  output  3  stat field of last stage.
- halted  output  1  pipeline frozen on non-AOK last-stage status.
- cycle_cnt  output  CNT_W  clocks elapsed while not halted.
- retire_cnt  output  CNT_W  non-NOP AOK instructions loaded into last stage.
- bubble_cnt  output  CNT_W  bubbles inserted at stage 1 (E).

Behaviour:
- Encodings: AOK=1, HLT=2, ADR=3, INS=4; icode NOP=1.
- NOP payload: stat=1, icode=1, all other bits 0.
- Reset (rst_n low, asynchronous): every stage = NOP payload; halted=0; all counters 0. Applies immediately, including mid-operation; no partial updates survive.
- Per stage s at posedge, when not halted:
  - stall[s]=1: hold current value. Stall wins over bubble when both are set.
  - else bubble[s]=1: load NOP payload.
  - else: load slice s of d_in.
- Latency: one clock per stage. No internal stage-to-stage chaining; the top wires stage logic outputs into d_in.
- halted:
  - Combinationally asserted when q_out last-stage stat != 1. Registered copy is sticky.
  - halted output = combinational OR sticky.
  - While halted, all stages hold regardless of stall/bubble, and all counters hold.
  - Cleared only by reset.
- stat output = q_out last-stage stat field, combinational.
- cycle_cnt: +1 every posedge while halted=0.
- retire_cnt: +1 when the last stage loads (not stall, not bubble, not halted) a payload with icode != 1 and stat == 1.
- bubble_cnt: +1 when stage 1 loads a bubble (bubble[1]=1, stall[1]=0, not halted). When STAGES==1, uses stage 0.
- Counter overflow: all counters saturate at all-ones; no wrap.
- Simultaneous events: a non-AOK payload entering the last stage freezes the pipeline starting the next edge. The halting instruction itself does not increment retire_cnt.
- Legal: STAGES>=1, PAYLOAD_W>=7. Other values fail elaboration via generate-time check.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined: cycle_cnt, retire_cnt and bubble_cnt implemented as above.
- Undefined: no counter flops; all three outputs tied to 0. Stage and halt behaviour unchanged.

Test Plan:
- Reset: hold rst_n=0 mid-run, then release -> every q_out slice = stat 1, icode 1, rest 0; halted=0; counters 0.
- Flow-through, STAGES=4: inject icode=6 (OPq) payload 0xA5 tag at stage 0 and shift each cycle via d_in wiring -> tag in last stage after 4 clocks; retire_cnt=1; cycle_cnt=4.
- Stall priority: stall[0]=1 and bubble[0]=1 with d_in slice 0 = icode 3 -> stage 0 unchanged. Then stall[0]=0, bubble[0]=1 -> stage 0 = NOP; bubble_cnt unaffected. Then bubble[1]=1 -> bubble_cnt increments by 1.
- Halt: drive last-stage d_in stat=2 (HLT), icode=0 -> next edge stat=2, halted=1. Further edges with random d_in/stall/bubble -> q_out and counters frozen. Reset clears halted.
- Saturation, CNT_W=4: run 20 non-halted cycles -> cycle_cnt=15 and stays 15.
- PIPE_PERF_EN undefined: flow-through test -> counters read 0; q_out identical to the macro-defined run.
